ysyx_23060187_ifu: RTL

Instruction fetch unit of the ysyx_23060187 multicycle NPC core, directly upstream of the IDU. It holds the PC and issues one AXI4-Lite-style read per instruction to instruction memory. It presents the fetched word and its PC to the IDU over the IFU_IDU_valid/IDU_IFU_ready handshake, then waits for the next PC from write-back before fetching again. Bus error responses, response timeouts and misaligned next-PCs stop the unit in a sticky fault state.

---
 rtl/ysyx_23060187_pkg.sv | 24 ++
 rtl/ysyx_23060187_ifu.sv | 109 ++++++++++
 2 files changed

// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 core: IFU state encoding,
// bus response codes and the common reset PC.
package ysyx_23060187_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE    = 3'd0,
        IFU_REQ     = 3'd1,
        IFU_RESP    = 3'd2,
        IFU_HOLD    = 3'd3,
        IFU_WAIT_PC = 3'd4,
        IFU_FAULT   = 3'd5
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    // Also used by the CSR / difftest setup, so it lives here.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Instruction addresses must be word aligned.
    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: one AXI4-Lite-style read per instruction,
// hands the word to the IDU, then waits for the next PC from write-back.
// Bus errors, response timeouts and misaligned next-PCs park the unit in
// a sticky FAULT state that only reset clears.
module ysyx_23060187_ifu
    import ysyx_23060187_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic [31:0] IFU_inst,
    output logic [31:0] IFU_pc,
    output logic        IFU_IDU_valid,
    input  logic        IDU_IFU_ready,
    input  logic        WBU_IFU_valid,
    input  logic [31:0] WBU_dnpc,
    output logic        IFU_WBU_ready,
    output logic        ifu_fault
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    ifu_state_e       state;
    ifu_state_e       state_nxt;
    logic [31:0]      pc;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;
    logic             resp_fire;
    logic             resp_ok;

    // The fetch address is the PC register itself, so it cannot move
    // while an address request is outstanding.
    assign ifu_araddr  = pc;
    assign timeout_hit = (timeout_cnt == CNT_MAX);
    assign resp_fire   = (state == IFU_RESP) && ifu_rvalid;
    assign resp_ok     = (ifu_rresp == RESP_OKAY);

    // Next-state decode; a response in the timeout cycle takes priority.
    always_comb begin
        state_nxt = state;
        case (state)
            IFU_IDLE:    state_nxt = IFU_REQ;
            IFU_REQ:     if (ifu_arready) state_nxt = IFU_RESP;
            IFU_RESP: begin
                if (ifu_rvalid)
                    state_nxt = resp_ok ? IFU_HOLD : IFU_FAULT;
                else if (timeout_hit)
                    state_nxt = IFU_FAULT;
            end
            IFU_HOLD:    if (IDU_IFU_ready) state_nxt = IFU_WAIT_PC;
            IFU_WAIT_PC: begin
                if (WBU_IFU_valid)
                    state_nxt = pc_misaligned(WBU_dnpc) ? IFU_FAULT : IFU_REQ;
            end
            IFU_FAULT:   state_nxt = IFU_FAULT;
            default:     state_nxt = IFU_FAULT;
        endcase
    end

    // State, PC, captured instruction, timeout counter and registered handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IFU_IDLE;
            pc            <= RESET_PC;
            IFU_inst      <= '0;
            IFU_pc        <= RESET_PC;
            timeout_cnt   <= '0;
            ifu_arvalid   <= 1'b0;
            ifu_rready    <= 1'b0;
            IFU_IDU_valid <= 1'b0;
            IFU_WBU_ready <= 1'b0;
            ifu_fault     <= 1'b0;
        end else begin
            state         <= state_nxt;
            ifu_arvalid   <= (state_nxt == IFU_REQ);
            ifu_rready    <= (state_nxt == IFU_RESP);
            IFU_IDU_valid <= (state_nxt == IFU_HOLD);
            IFU_WBU_ready <= (state_nxt == IFU_WAIT_PC);
            ifu_fault     <= (state_nxt == IFU_FAULT);

            // Counter restarts on every address handshake and stops at the limit.
            if ((state == IFU_REQ) && ifu_arready)
                timeout_cnt <= '0;
            else if ((state == IFU_RESP) && !ifu_rvalid && !timeout_hit)
                timeout_cnt <= timeout_cnt + 1'b1;

            // Instruction and its PC are captured together so they always match.
            if (resp_fire && resp_ok) begin
                IFU_inst <= ifu_rdata;
                IFU_pc   <= pc;
            end

            // A misaligned next-PC is rejected and the old PC is kept.
            if ((state == IFU_WAIT_PC) && WBU_IFU_valid && !pc_misaligned(WBU_dnpc))
                pc <= WBU_dnpc;
        end
    end

endmodule
